// File: rtl/spi_reg_target.sv
// SPI target exposing a bank of DATA_WIDTH-bit registers: command byte, then a
// data burst with address auto-increment. All SPI inputs are oversampled on clk.
module spi_reg_target #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_cpol,
  input  logic                                   cfg_cpha,
  input  logic                                   sclk_in,
  input  logic                                   ss_n_in,
  input  logic                                   mosi_in,
  output logic                                   miso,
  output logic                                   miso_oe,
  output logic                                   wr_valid,
  output logic [ADDR_WIDTH-1:0]                  wr_addr,
  output logic [DATA_WIDTH-1:0]                  wr_data,
  output logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0]  regs_flat,
  output logic                                   busy
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam int CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH-1);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sclk_sync;
  logic [SYNC_STAGES-1:0]   ss_n_sync;
  logic [SYNC_STAGES-1:0]   mosi_sync;
  logic                     sclk_prev;
  logic                     ss_n_prev;
  logic [CNT_W-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0]    rx;
  logic [DATA_WIDTH-1:0]    tx;
  logic                     hold;
  logic                     rw;
  logic [ADDR_WIDTH-1:0]    addr;
  logic [DATA_WIDTH-1:0]    regs [NUM_REGS];

  logic                     sclk_s;
  logic                     ss_n_s;
  logic                     mosi_s;
  logic                     sclk_rise;
  logic                     sclk_fall;
  logic                     sample_edge;
  logic                     shift_edge;
  logic                     ss_fall;
  logic                     ss_rise;
  logic [DATA_WIDTH-1:0]    rx_next;
  logic [ADDR_WIDTH-1:0]    addr_inc;

  // Idle levels on reset so that no spurious edge is seen after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{cfg_cpol}};
      ss_n_sync <= '1;
      mosi_sync <= '0;
      sclk_prev <= cfg_cpol;
      ss_n_prev <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], ss_n_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sclk_prev <= sclk_s;
      ss_n_prev <= ss_n_s;
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign ss_n_s      = ss_n_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev;
  assign sclk_fall   = ~sclk_s & sclk_prev;
  assign sample_edge = (cfg_cpol == cfg_cpha) ? sclk_rise : sclk_fall;
  assign shift_edge  = (cfg_cpol == cfg_cpha) ? sclk_fall : sclk_rise;
  assign ss_fall     = ss_n_prev & ~ss_n_s;
  assign ss_rise     = ~ss_n_prev & ss_n_s;
  assign rx_next     = {rx[DATA_WIDTH-2:0], mosi_s};
  assign addr_inc    = addr + 1'b1;

  // hold suppresses the one shift edge that must present a freshly loaded MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx       <= '0;
      tx       <= '0;
      hold     <= 1'b0;
      rw       <= 1'b0;
      addr     <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (ss_rise) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
              tx      <= '0;
              hold    <= cfg_cpha;
            end
          end
          CMD, DATA: begin
            if (shift_edge) begin
              if (hold) hold <= 1'b0;
              else      tx   <= {tx[DATA_WIDTH-2:0], 1'b0};
            end
            if (sample_edge) begin
              rx      <= rx_next;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_LAST) begin
                bit_cnt <= '0;
                hold    <= 1'b1;
                if (state == CMD) begin
                  state <= DATA;
                  rw    <= rx_next[DATA_WIDTH-1];
                  addr  <= rx_next[ADDR_WIDTH-1:0];
                  if (rx_next[DATA_WIDTH-1]) tx <= regs[rx_next[ADDR_WIDTH-1:0]];
                end else begin
                  addr <= addr_inc;
                  if (rw) begin
                    tx <= regs[addr_inc];
                  end else begin
                    regs[addr] <= rx_next;
                    wr_valid   <= 1'b1;
                    wr_addr    <= addr;
                    wr_data    <= rx_next;
                  end
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign miso_oe = ~ss_n_s;
  assign busy    = ~ss_n_s;
  assign miso    = miso_oe & tx[DATA_WIDTH-1];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
    end
  endgenerate

endmodule

// File: tb/tb_spi_reg_target.sv
// Randomised bench for spi_reg_target: a bit-level SPI initiator plus a
// byte-level register-bank model that predicts writes and read-back data.
module tb_spi_reg_target;
  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int SS   = 2;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_cpol = 1'b0;
  logic cfg_cpha = 1'b0;
  logic sclk_in = 1'b0;
  logic ss_n_in = 1'b1;
  logic mosi_in = 1'b0;
  logic miso, miso_oe, wr_valid, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW*16-1:0] regs_flat;

  spi_reg_target #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .sclk_in(sclk_in), .ss_n_in(ss_n_in), .mosi_in(mosi_in),
    .miso(miso), .miso_oe(miso_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .regs_flat(regs_flat), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  model_regs [16];
  logic [7:0]  mosi_buf [8];
  logic [7:0]  miso_buf [8];
  logic [11:0] wq [$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = model_regs[i];
    return r;
  endfunction

  always @(negedge clk) if (rst_n && wr_valid) wq.push_back({wr_addr, wr_data});

  task automatic set_mode(input logic cpol, input logic cpha);
    cfg_cpol = cpol;
    cfg_cpha = cpha;
    sclk_in  = cpol;
    repeat (6) @(negedge clk);
  endtask

  // Initiator: drives nbits from mosi_buf, captures miso at each sample edge.
  task automatic spi_frame(input int nbits, input bit rst_mid);
    ss_n_in = 1'b0;
    repeat (HALF) @(negedge clk);
    check_eq("busy in frame", busy, 1'b1);
    for (int b = 0; b < nbits; b++) begin
      logic [7:0] mb;
      mb = mosi_buf[b/8];
      if (!cfg_cpha) begin
        mosi_in = mb[7-(b%8)];
        repeat (HALF) @(negedge clk);
        miso_buf[b/8][7-(b%8)] = miso;
        sclk_in = ~cfg_cpol;
        repeat (HALF) @(negedge clk);
        sclk_in = cfg_cpol;
      end else begin
        sclk_in = ~cfg_cpol;
        mosi_in = mb[7-(b%8)];
        repeat (HALF) @(negedge clk);
        miso_buf[b/8][7-(b%8)] = miso;
        sclk_in = cfg_cpol;
        repeat (HALF) @(negedge clk);
      end
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      #1;
      check_eq("rst regs_flat", regs_flat, '0);
      check_eq("rst miso_oe", miso_oe, 1'b0);
      check_eq("rst miso", miso, 1'b0);
      check_eq("rst wr_valid", wr_valid, 1'b0);
      check_eq("rst busy", busy, 1'b0);
      check_eq("rst wr_addr/data", {wr_addr, wr_data}, 12'h0);
      ss_n_in = 1'b1;
      sclk_in = cfg_cpol;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
      wq.delete();
    end else begin
      repeat (HALF) @(negedge clk);
      ss_n_in = 1'b1;
      repeat (HALF + 4) @(negedge clk);
    end
  endtask

  task automatic run_frame(input string name, input int nbits);
    logic [7:0]  exp_miso [8];
    logic [11:0] exp_w [$];
    int nfull, a, nw;
    bit rw;
    nfull = nbits / 8;
    for (int i = 0; i < 8; i++) exp_miso[i] = 8'h00;
    if (nfull >= 1) begin
      rw = mosi_buf[0][7];
      a  = int'(mosi_buf[0][3:0]);
      for (int i = 1; i < nfull; i++) begin
        if (rw) exp_miso[i] = model_regs[a];
        else begin
          model_regs[a] = mosi_buf[i];
          exp_w.push_back({4'(a), mosi_buf[i]});
        end
        a = (a + 1) % 16;
      end
    end
    wq.delete();
    spi_frame(nbits, 1'b0);
    for (int i = 0; i < nfull; i++)
      check_eq($sformatf("%s miso byte%0d", name, i), miso_buf[i], exp_miso[i]);
    check_eq({name, " wr count"}, wq.size(), exp_w.size());
    nw = (wq.size() < exp_w.size()) ? wq.size() : exp_w.size();
    for (int i = 0; i < nw; i++)
      check_eq($sformatf("%s write%0d addr/data", name, i), wq[i], exp_w[i]);
    check_eq({name, " regs_flat"}, regs_flat, model_flat());
    check_eq({name, " idle busy/oe"}, {busy, miso_oe}, 2'b00);
    $display("[TB] frame %s mode %0d%0d bits %0d writes %0d", name, cfg_cpol, cfg_cpha, nbits, wq.size());
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset regs_flat", regs_flat, '0);
    check_eq("reset outs", {miso, miso_oe, wr_valid, busy}, 4'b0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("post-reset outs", {miso, miso_oe, wr_valid, busy}, 4'b0000);

    set_mode(1'b0, 1'b0);
    mosi_buf[0] = 8'h02; mosi_buf[1] = 8'h3C; run_frame("wr2", 16);
    check_eq("regs[2]", regs_flat[23:16], 8'h3C);
    mosi_buf[0] = 8'h82; mosi_buf[1] = 8'h00; run_frame("rd2", 16);

    mosi_buf[0] = 8'h0E; mosi_buf[1] = 8'h11; mosi_buf[2] = 8'h22; mosi_buf[3] = 8'h33;
    run_frame("burst wr", 32);
    mosi_buf[0] = 8'h8E; mosi_buf[1] = 8'h00; mosi_buf[2] = 8'h00; mosi_buf[3] = 8'h00;
    run_frame("burst rd", 32);
    check_eq("burst rd data", {miso_buf[1], miso_buf[2], miso_buf[3]}, 24'h112233);

    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0]);
      mosi_buf[0] = 8'h05; mosi_buf[1] = 8'hA5; run_frame($sformatf("wr5 m%0d", m), 16);
      mosi_buf[0] = 8'h85; mosi_buf[1] = 8'h00; run_frame($sformatf("rd5 m%0d", m), 16);
      check_eq($sformatf("rd5 m%0d A5", m), miso_buf[1], 8'hA5);
    end

    set_mode(1'b0, 1'b0);
    mosi_buf[0] = 8'h03; mosi_buf[1] = 8'h77; run_frame("wr3", 16);
    mosi_buf[0] = 8'h03; mosi_buf[1] = 8'h00; run_frame("wr3 partial", 12);
    check_eq("regs[3] kept", regs_flat[31:24], 8'h77);
    mosi_buf[0] = 8'h83; mosi_buf[1] = 8'h00; run_frame("rd3 after partial", 16);

    for (int f = 0; f < 16; f++) begin
      int nbytes, nbits;
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nbytes = $urandom_range(1, 5);
      for (int i = 0; i < nbytes; i++) mosi_buf[i] = 8'($urandom);
      nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nbytes * 8) : nbytes * 8;
      run_frame($sformatf("rand%0d", f), nbits);
    end

    set_mode(1'b0, 1'b0);
    mosi_buf[0] = 8'h07; mosi_buf[1] = 8'h5A;
    spi_frame(12, 1'b1);
    check_eq("post-rst regs_flat", regs_flat, '0);
    mosi_buf[0] = 8'h01; mosi_buf[1] = 8'hC3; run_frame("wr1 after rst", 16);
    check_eq("regs[1]", regs_flat[15:8], 8'hC3);
    mosi_buf[0] = 8'h81; mosi_buf[1] = 8'h00; run_frame("rd1 after rst", 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
